j1_boot_ctrl: RTL and testbench
===============================

# j1_boot_ctrl

Boot sequencer for the J1 core. Holds the CPU in reset after power-up or on request, receives a program image as a byte stream, and writes it word by word into the instruction/data RAM through the RAM's otherwise unused port-A write side. It verifies a checksum, then releases the CPU so that it starts at PC 0. `cpu_rst_o` drives the core's active-high `sys_rst_i`.

## Interface
Parameters:
- ADDR_W, 13, RAM word-address width; the maximum image size is 2^ADDR_W words.
- MAGIC, 16'hA55A, header word, sent low byte first.

Ports:
- sys_clk_i  in  1  system clock; single clock domain.
- sys_rst_n_i  in  1  reset, synchronous, active-low.
- rx_data_i  in  8  stream byte.
- rx_valid_i  in  1  byte valid.
- rx_ready_o  out  1  byte accepted when rx_valid_i && rx_ready_o at a rising edge.
- boot_req_i  in  1  single-cycle request to reload; sampled every cycle.
- mem_addr_o  out  ADDR_W  RAM word address.
- mem_data_o  out  16  RAM write data.
- mem_we_o  out  1  RAM write strobe, one cycle per word.
- cpu_rst_o  out  1  CPU reset, active-high.
- busy_o  out  1  high while not in RUN.
- err_o  out  1  sticky error flag.

## Operation
- States: MAGIC_LO, MAGIC_HI, CNT_LO, CNT_HI, DATA_LO, DATA_HI, CSUM, RUN. The state advances only on an accepted byte, except where noted below.
- Byte order is little-endian throughout: low byte first for MAGIC, the 16-bit count N, and each data word.
- MAGIC_LO:
  - byte == MAGIC[7:0] -> MAGIC_HI.
  - otherwise stay.
- MAGIC_HI:
  - byte == MAGIC[15:8] -> CNT_LO; err_o cleared; checksum register cleared; word index cleared.
  - else if byte == MAGIC[7:0] -> stay.
  - else -> MAGIC_LO.
- Checksum: XOR of the two count bytes and all data bytes. The magic and checksum bytes are excluded.
- CNT_HI:
  - N > 2^ADDR_W -> err_o=1, MAGIC_LO.
  - N == 0 -> CSUM.
  - otherwise -> DATA_LO.
- DATA_LO latches the low byte.
- DATA_HI issues a write: mem_addr_o = word index, mem_data_o = {hi, lo}, mem_we_o = 1 for exactly one cycle. Then the index increments.
  - index+1 == N -> CSUM.
  - else -> DATA_LO.
- The index is ADDR_W+1 bits wide so that N = 2^ADDR_W terminates correctly. mem_addr_o takes the low ADDR_W bits.
- CSUM:
  - byte == checksum -> RUN, cpu_rst_o=0.
  - mismatch -> err_o=1, MAGIC_LO, and the CPU stays in reset.
- RUN: rx_ready_o=0 and incoming bytes are ignored. On boot_req_i -> MAGIC_LO, cpu_rst_o=1, err_o=0.
- boot_req_i in any load state: abort to MAGIC_LO, clear err_o. A byte accepted in the same cycle is discarded. boot_req_i has priority over every byte transition.
- rx_ready_o = (state != RUN) while sys_rst_n_i is high, and 0 while sys_rst_n_i is low. There is no internal backpressure: every load state accepts a byte every cycle.
- busy_o = (state != RUN).

## Timing
- All outputs except rx_ready_o are registered.
- Reset values (sys_rst_n_i low at an edge):
  - state MAGIC_LO
  - cpu_rst_o=1, busy_o=1, err_o=0
  - mem_we_o=0, mem_addr_o=0, mem_data_o=0
  - rx_ready_o=0 during reset, 1 in the first cycle after release.
- Reset asserted mid-load: abort immediately. No further writes; RAM contents already written are left untouched.
- Write latency: DATA_HI byte accepted at edge k -> mem_we_o, mem_addr_o and mem_data_o valid in the cycle after edge k. mem_we_o drops at edge k+1 unless another write follows. mem_addr_o and mem_data_o hold their last values between writes.
- Back-to-back writes are spaced at least 2 cycles apart, because each word takes two bytes.
- Release: a good CSUM byte accepted at edge k -> cpu_rst_o=0 and busy_o=0 after edge k. The last write (edge k-1 or earlier) has completed before release.
- Error: err_o rises after the offending edge.
- Reload: boot_req_i high at edge k -> cpu_rst_o=1 and busy_o=1 after edge k. rx_ready_o=1 from the same point.
- The minimum load time for N words is 2N+5 accepted bytes.

## Test plan
- Reset, then stream 5A A5 02 00 34 12 78 56 0A with valid held high -> writes (0,1234h) and (1,5678h) on separate single cycles; cpu_rst_o falls after the 0A byte; err_o=0; rx_ready_o=0 afterwards.
- Same image with checksum byte 0B -> err_o=1, cpu_rst_o stays 1, state MAGIC_LO. Then resend the correct image -> err_o clears at the A5 byte and the CPU releases.
- Leading junk 00 5A 5A A5 then count 00 00, checksum 00 -> the header syncs on the second 5A, no mem_we_o pulse, release after the checksum byte.
- Count 2001h with ADDR_W=13 -> err_o=1 after the count high byte, no writes, next byte is treated as MAGIC_LO.
- In RUN, pulse boot_req_i -> cpu_rst_o=1 the next cycle, rx_ready_o=1. Pulse boot_req_i while a DATA_HI byte is accepted mid-load -> no write for that byte, state MAGIC_LO.
- Drop sys_rst_n_i after the third data byte of a 4-word image -> mem_we_o=0, cpu_rst_o=1, rx_ready_o=0 during reset. After release a full reload succeeds.

Source files
------------

// File: rtl/j1_boot_ctrl_if.sv
// rtl/j1_boot_ctrl_if.sv - byte stream and RAM write bus of the J1 boot sequencer
interface j1_boot_ctrl_if #(
  parameter int ADDR_W = 13
);
  logic [7:0]        rx_data_i;
  logic              rx_valid_i;
  logic              rx_ready_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [15:0]       mem_data_o;
  logic              mem_we_o;

  // stream source / RAM sink side
  modport master (
    output rx_data_i, rx_valid_i,
    input  rx_ready_o, mem_addr_o, mem_data_o, mem_we_o
  );

  // boot sequencer side
  modport slave (
    input  rx_data_i, rx_valid_i,
    output rx_ready_o, mem_addr_o, mem_data_o, mem_we_o
  );
endinterface

// File: rtl/j1_boot_ctrl.sv
// rtl/j1_boot_ctrl.sv - J1 boot sequencer: byte-stream image loader with checksum and CPU release
module j1_boot_ctrl #(
  parameter int          ADDR_W = 13,
  parameter logic [15:0] MAGIC  = 16'hA55A
) (
  input  logic         sys_clk_i,
  input  logic         sys_rst_n_i,
  input  logic         boot_req_i,
  j1_boot_ctrl_if.slave bus,
  output logic         cpu_rst_o,
  output logic         busy_o,
  output logic         err_o
);

  localparam logic [2:0] MAGIC_LO = 3'd0;
  localparam logic [2:0] MAGIC_HI = 3'd1;
  localparam logic [2:0] CNT_LO   = 3'd2;
  localparam logic [2:0] CNT_HI   = 3'd3;
  localparam logic [2:0] DATA_LO  = 3'd4;
  localparam logic [2:0] DATA_HI  = 3'd5;
  localparam logic [2:0] CSUM     = 3'd6;
  localparam logic [2:0] RUN      = 3'd7;

  // largest legal word count; 17 bits so 2^16 would still be representable
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  logic [2:0]        state;
  logic [7:0]        csum;
  logic [ADDR_W:0]   idx;      // one extra bit so a full RAM load terminates
  logic [15:0]       cnt;
  logic [7:0]        lo_byte;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic              mem_we;
  logic              ready;
  logic              accept;
  logic [ADDR_W:0]   idx_nxt;
  logic [15:0]       n_word;
  logic [7:0]        rx_byte;

  assign rx_byte        = bus.rx_data_i;
  assign ready          = sys_rst_n_i && (state != RUN);
  assign accept         = bus.rx_valid_i && ready;
  assign idx_nxt        = idx + (ADDR_W+1)'(1);
  assign n_word         = {rx_byte, cnt[7:0]};
  assign bus.rx_ready_o = ready;
  assign bus.mem_addr_o = mem_addr;
  assign bus.mem_data_o = mem_data;
  assign bus.mem_we_o   = mem_we;
  assign busy_o         = (state != RUN);

  // load sequencer: header sync, count, word writes, checksum, release and reload
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      state     <= MAGIC_LO;
      cpu_rst_o <= 1'b1;
      err_o     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      csum      <= '0;
      idx       <= '0;
      cnt       <= '0;
      lo_byte   <= '0;
    end else begin
      mem_we <= 1'b0;
      if (boot_req_i) begin
        // reload wins over any byte accepted in the same cycle
        state     <= MAGIC_LO;
        cpu_rst_o <= 1'b1;
        err_o     <= 1'b0;
      end else if (accept) begin
        case (state)
          MAGIC_LO: begin
            if (rx_byte == MAGIC[7:0]) state <= MAGIC_HI;
          end
          MAGIC_HI: begin
            if (rx_byte == MAGIC[15:8]) begin
              state <= CNT_LO;
              err_o <= 1'b0;
              csum  <= '0;
              idx   <= '0;
            end else if (rx_byte != MAGIC[7:0]) begin
              state <= MAGIC_LO;
            end
          end
          CNT_LO: begin
            cnt[7:0] <= rx_byte;
            csum     <= csum ^ rx_byte;
            state    <= CNT_HI;
          end
          CNT_HI: begin
            cnt  <= n_word;
            csum <= csum ^ rx_byte;
            if ({1'b0, n_word} > MAX_WORDS) begin
              err_o <= 1'b1;
              state <= MAGIC_LO;
            end else if (n_word == 16'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA_LO;
            end
          end
          DATA_LO: begin
            lo_byte <= rx_byte;
            csum    <= csum ^ rx_byte;
            state   <= DATA_HI;
          end
          DATA_HI: begin
            mem_we   <= 1'b1;
            mem_addr <= idx[ADDR_W-1:0];
            mem_data <= {rx_byte, lo_byte};
            csum     <= csum ^ rx_byte;
            idx      <= idx_nxt;
            state    <= (17'(idx_nxt) == {1'b0, cnt}) ? CSUM : DATA_LO;
          end
          CSUM: begin
            if (rx_byte == csum) begin
              state     <= RUN;
              cpu_rst_o <= 1'b0;
            end else begin
              err_o <= 1'b1;
              state <= MAGIC_LO;
            end
          end
          default: state <= MAGIC_LO;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_j1_boot_ctrl.sv
// tb/tb_j1_boot_ctrl.sv - self-checking bench for j1_boot_ctrl
module tb_j1_boot_ctrl;
  localparam int ADDR_W = 13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic boot_req = 1'b0;
  logic cpu_rst, busy, err;

  int checks = 0;
  int errors = 0;

  j1_boot_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  j1_boot_ctrl #(.ADDR_W(ADDR_W), .MAGIC(16'hA55A)) dut (
    .sys_clk_i   (clk),
    .sys_rst_n_i (rst_n),
    .boot_req_i  (boot_req),
    .bus         (bus.slave),
    .cpu_rst_o   (cpu_rst),
    .busy_o      (busy),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  // reference model state: image words and the RAM writes they must produce
  logic [15:0]         img[$];
  logic [ADDR_W+15:0]  exp_wr[$];
  logic [ADDR_W+15:0]  obs_wr[$];

  // record every write strobe seen on the RAM bus
  always @(negedge clk)
    if (bus.mem_we_o) obs_wr.push_back({bus.mem_addr_o, bus.mem_data_o});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data_i  = b;
    bus.rx_valid_i = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.rx_valid_i = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reload();
    bus.rx_valid_i = 1'b0;
    boot_req = 1'b1;
    @(posedge clk);
    #1;
    boot_req = 1'b0;
    chk("reload_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("reload_busy", 32'(busy), 32'd1);
    chk("reload_rx_ready", 32'(bus.rx_ready_o), 32'd1);
    chk("reload_err", 32'(err), 32'd0);
  endtask

  // stream the image in img; the checksum is XOR of count and data bytes
  task automatic send_image(input bit bad, input bit gaps);
    logic [7:0] bytes[$];
    logic [7:0] cs;
    int n;
    n = img.size();
    bytes.push_back(8'h5A);
    bytes.push_back(8'hA5);
    bytes.push_back(n[7:0]);
    bytes.push_back(n[15:8]);
    cs = n[7:0] ^ n[15:8];
    for (int i = 0; i < n; i++) begin
      bytes.push_back(img[i][7:0]);
      bytes.push_back(img[i][15:8]);
      cs = cs ^ img[i][7:0] ^ img[i][15:8];
      exp_wr.push_back({i[ADDR_W-1:0], img[i]});
    end
    bytes.push_back(bad ? (cs ^ 8'h01) : cs);
    foreach (bytes[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) idle(1);
      send(bytes[i]);
    end
    idle(1);
  endtask

  task automatic cmp_writes(input string tag);
    int m;
    chk({tag, "_wr_count"}, 32'(obs_wr.size()), 32'(exp_wr.size()));
    m = (obs_wr.size() < exp_wr.size()) ? obs_wr.size() : exp_wr.size();
    for (int i = 0; i < m; i++)
      chk({tag, "_wr"}, 32'(obs_wr[i]), 32'(exp_wr[i]));
    obs_wr.delete();
    exp_wr.delete();
  endtask

  task automatic chk_run(input string tag, input bit ok);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), ok ? 32'd0 : 32'd1);
    chk({tag, "_busy"}, 32'(busy), ok ? 32'd0 : 32'd1);
    chk({tag, "_err"}, 32'(err), ok ? 32'd0 : 32'd1);
    chk({tag, "_rx_ready"}, 32'(bus.rx_ready_o), ok ? 32'd0 : 32'd1);
  endtask

  initial begin
    bus.rx_data_i  = 8'h00;
    bus.rx_valid_i = 1'b0;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_we", 32'(bus.mem_we_o), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr_o), 32'd0);
    chk("rst_data", 32'(bus.mem_data_o), 32'd0);
    chk("rst_rx_ready", 32'(bus.rx_ready_o), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_rx_ready", 32'(bus.rx_ready_o), 32'd1);

    // basic two-word image with write latency and hold checks
    send(8'h5A); send(8'hA5); send(8'h02); send(8'h00); send(8'h34);
    chk("lo_no_we", 32'(bus.mem_we_o), 32'd0);
    send(8'h12);
    chk("w0_we", 32'(bus.mem_we_o), 32'd1);
    chk("w0_addr", 32'(bus.mem_addr_o), 32'd0);
    chk("w0_data", 32'(bus.mem_data_o), 32'h1234);
    send(8'h78);
    chk("w0_drop", 32'(bus.mem_we_o), 32'd0);
    chk("w0_hold", 32'(bus.mem_data_o), 32'h1234);
    send(8'h56);
    chk("w1_we", 32'(bus.mem_we_o), 32'd1);
    chk("w1_addr", 32'(bus.mem_addr_o), 32'd1);
    chk("w1_data", 32'(bus.mem_data_o), 32'h5678);
    chk("pre_csum_cpu_rst", 32'(cpu_rst), 32'd1);
    send(8'h0A);
    chk_run("basic", 1'b1);
    send(8'h5A);
    chk("run_ignores", 32'(busy), 32'd0);
    idle(1);
    exp_wr.push_back({13'd0, 16'h1234});
    exp_wr.push_back({13'd1, 16'h5678});
    cmp_writes("basic");

    // bad checksum then good reload
    reload();
    img = '{16'h1234, 16'h5678};
    send_image(1'b1, 1'b0);
    chk_run("bad_csum", 1'b0);
    send(8'h5A);
    chk("err_kept", 32'(err), 32'd1);
    send(8'hA5);
    chk("err_cleared", 32'(err), 32'd0);
    send(8'h02); send(8'h00); send(8'h34); send(8'h12);
    send(8'h78); send(8'h56); send(8'h0A);
    chk_run("resend", 1'b1);
    idle(1);
    exp_wr.push_back({13'd0, 16'h1234});
    exp_wr.push_back({13'd1, 16'h5678});
    cmp_writes("bad_resend");

    // junk before header, zero-length image
    reload();
    send(8'h00); send(8'h5A); send(8'h5A); send(8'hA5);
    send(8'h00); send(8'h00); send(8'h00);
    chk_run("junk", 1'b1);
    idle(1);
    cmp_writes("junk");

    // oversize count, then next byte starts header hunt
    reload();
    send(8'h5A); send(8'hA5); send(8'h01); send(8'h20);
    chk("oversize_err", 32'(err), 32'd1);
    chk("oversize_cpu_rst", 32'(cpu_rst), 32'd1);
    send(8'h5A); send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
    chk_run("after_oversize", 1'b1);
    idle(1);
    cmp_writes("oversize");

    // reload request coinciding with a DATA_HI byte
    reload();
    send(8'h5A); send(8'hA5); send(8'h02); send(8'h00); send(8'h34);
    boot_req = 1'b1;
    send(8'h12);
    boot_req = 1'b0;
    chk("abort_we", 32'(bus.mem_we_o), 32'd0);
    chk("abort_busy", 32'(busy), 32'd1);
    img = '{16'hBEEF};
    send_image(1'b0, 1'b0);
    chk_run("after_abort", 1'b1);
    cmp_writes("abort");

    // reset mid-load of a 4-word image
    reload();
    send(8'h5A); send(8'hA5); send(8'h04); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33);
    rst_n = 1'b0;
    bus.rx_valid_i = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_we", 32'(bus.mem_we_o), 32'd0);
    chk("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("midrst_rx_ready", 32'(bus.rx_ready_o), 32'd0);
    idle(2);
    rst_n = 1'b1;
    exp_wr.push_back({13'd0, 16'h2211});
    img = '{16'hA001, 16'hB002, 16'hC003, 16'hD004};
    send_image(1'b0, 1'b0);
    chk_run("after_midrst", 1'b1);
    cmp_writes("midrst");

    // randomized images against the model
    for (int it = 0; it < 20; it++) begin
      bit bad;
      int n;
      reload();
      img.delete();
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) img.push_back(16'($urandom));
      bad = ($urandom_range(0, 3) == 0);
      send_image(bad, 1'b1);
      chk_run("rand", !bad);
      cmp_writes("rand");
    end

    // full-RAM image: count exactly 2^ADDR_W
    reload();
    img.delete();
    for (int i = 0; i < (1 << ADDR_W); i++) img.push_back(16'($urandom));
    send_image(1'b0, 1'b0);
    chk_run("full", 1'b1);
    cmp_writes("full");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
